// File: rtl/rv_pipe_pkg.sv
// Shared types and helpers for the RV32I pipeline stall/flush sequencer.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    localparam int REG_NO_DEFAULT = 8;

    // A single-register file still needs a one-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squashes, memory hold-off freeze and hung-memory trap.
module pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int REG_NO      = REG_NO_DEFAULT,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    localparam int AW         = addr_width(REG_NO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    src1_add_DE,
    input  logic [AW-1:0]    src2_add_DE,
    input  logic [AW-1:0]    dest_add_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_ME,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_DE,
    output logic             stall_EX,
    output logic             stall_ME,
    output logic             flush_DE,
    output logic             flush_EX,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             WCW       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    pipe_state_e    state_q,    state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_q,  timeout_d;

    logic memwait_s;
    logic loaduse_s;
    logic br_flush_s;

    assign memwait_s = dmem_req_ME & ~dmem_ready;
    assign loaduse_s = mem_read_EX & (dest_add_EX != {AW{1'b0}}) &
                       ((dest_add_EX == src1_add_DE) | (dest_add_EX == src2_add_DE));

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= {WCW{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state: wait_cnt holds the number of memwait cycles already completed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (memwait_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    state_d    = RUN;
                end
            end
            MEM_WAIT: begin
                if (!memwait_s) begin
                    state_d    = RUN;
                    wait_cnt_d = {WCW{1'b0}};
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = HALT;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = {WCW{1'b0}};
            end
        endcase
    end

    // Outputs: HALT > memwait > branch > load-use; reset forces NOPs in.
    always_comb begin
        stall_IF   = 1'b0;
        stall_DE   = 1'b0;
        stall_EX   = 1'b0;
        stall_ME   = 1'b0;
        flush_DE   = 1'b0;
        flush_EX   = 1'b0;
        br_flush_s = 1'b0;
        if (rst) begin
            flush_DE = 1'b1;
            flush_EX = 1'b1;
        end else if ((state_q == HALT) || memwait_s) begin
            stall_IF = 1'b1;
            stall_DE = 1'b1;
            stall_EX = 1'b1;
            stall_ME = 1'b1;
        end else if (branch_taken_EX) begin
            flush_DE   = 1'b1;
            flush_EX   = 1'b1;
            br_flush_s = 1'b1;
        end else if (loaduse_s) begin
            stall_IF = 1'b1;
            stall_DE = 1'b1;
            flush_EX = 1'b1;
        end else begin
            br_flush_s = 1'b0;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_IF),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_flush_s),
        .count (flush_cnt)
    );

endmodule
